prism_sp_tx_csum_insert: RTL
============================

// Module: prism_sp_tx_csum_insert
// PURPOSE
// Downstream partner of the TX checksum stage. Holds each outgoing frame at its first word
//   until that frame's checksum entry is available, then streams the frame out unchanged except
//   for patching the IPv4 header checksum and the TCP/UDP checksum in place.
// Sits between the TX frame data FIFO and the MAC TX stream.
// Frame data and checksum entries arrive in the same frame order.
// PARAMETERS
// DATA_WIDTH    128  stream width; fixed 128 (16 bytes/word, byte n at bits [8n+:8])
// ENABLE_IP     1    1: patch IPv4 header checksum; 0: pass through
// ENABLE_L4     1    1: patch TCP/UDP checksum; 0: pass through
// PORTS
// clock          in   1    single clock
// resetn         in   1    synchronous, active-low reset
// s_valid        in   1    input word valid
// s_ready        out  1    input word accepted when s_valid && s_ready
// s_data         in   128  frame data
// s_sof          in   1    first word of frame
// s_eof          in   1    last word of frame
// tx_csum_fifo_r fifo_read_interface.master: rd_en out 1, rd_data in 36, empty in 1
//   rd_data[1:0]=eth_type, [17:2]=IP csum, [19:18]=ip_proto, [35:20]=L4 csum
// m_valid        out  1    output word valid
// m_ready        in   1    downstream accepts when m_valid && m_ready
// m_data         out  128  patched frame data
// m_sof, m_eof   out  1    sof/eof, registered alongside m_data
// BEHAVIOUR
// Reset values: s_ready=0, m_valid=0, m_sof=0, m_eof=0, rd_en=0, m_data=0, word count=0, state=IDLE.
// States:
// - IDLE: wait for !empty, then pulse rd_en for one cycle and go to FETCH.
// - FETCH: rd_data is valid the cycle after rd_en; latch the entry and go to STREAM.
// - STREAM: pass words through; on an accepted word with s_eof, go to IDLE.
// Flow control and latency:
// - s_ready = (state==STREAM) && (!m_valid || m_ready).
// - Latency is one cycle: an accepted input word appears on m_* the next cycle. No bubbles inside a frame.
// - m_valid is held, with m_data stable, while !m_ready.
// - First frame word: no input word is accepted before its checksum entry is latched.
// Word count wcnt:
// - Counts accepted words within the frame, 0-based; cleared at each sof.
// - Saturates at 3.
// Patch points (IHL=5 frames only; byte offsets are from the frame start):
// - IP patch, when eth_type==01 && ENABLE_IP:
//   word1, bytes 8/9 (frame bytes 24/25) <= csum[15:8] / csum[7:0].
// - TCP patch, when ip_proto==01 && ENABLE_L4:
//   word3, bytes 2/3 (frame bytes 50/51).
// - UDP patch, when ip_proto==10 && ENABLE_L4:
//   word2, bytes 8/9 (frame bytes 40/41).
//   A computed value of 16'h0000 is transmitted as 16'hFFFF (RFC 768).
// - Type 00 means no patch for that layer.
// - All other bytes pass through bit-exact.
// Boundary cases:
// - Frame ending before its patch word: the patch is skipped; the entry is still consumed (one entry per frame).
// - Single-word frame (sof && eof): passed through; one entry consumed.
// - s_sof asserted while in STREAM: treated as data (no resync); the frame ends only on eof.
// - empty=1 in IDLE: stall indefinitely with s_ready=0.
// - Reset mid-frame: all state is dropped and outputs return to their reset values.
//   The upstream FIFOs are reset together with this block.
// TESTING
// 1. IPv4/UDP frame of 5 words, entry {L4=16'h1234, proto=10, IP=16'hB861, eth=01}
//    -> m word1 bytes 8/9 = B8,61; word2 bytes 8/9 = 12,34; all other bytes unchanged.
// 2. IPv4/TCP frame of 6 words, L4=16'hABCD -> word3 bytes 2/3 = AB,CD; word2 unchanged.
// 3. UDP entry with L4=16'h0000 -> word2 bytes 8/9 = FF,FF.
// 4. eth_type=00, 3-word frame -> output identical to input; one entry popped.
//    Next frame patched with its own entry.
// 5. Frame presented with the checksum FIFO empty for 10 cycles
//    -> s_ready=0 throughout; rd_en pulses exactly once after empty drops.
// 6. m_ready toggled randomly across back-to-back TCP frames -> no lost or duplicated words;
//    patches land at the correct words; resetn=0 mid-frame -> m_valid=0 the next cycle.

Source files
------------

// File: rtl/prism_sp_tx_csum_insert.sv
// TX checksum insertion: holds each frame at its first word until its checksum entry is
// fetched, then streams the frame through with the IPv4 and TCP/UDP checksum fields patched.
module prism_sp_tx_csum_insert #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter bit          ENABLE_IP  = 1'b1,
  parameter bit          ENABLE_L4  = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eof,
  output logic                  tx_csum_fifo_r_rd_en,
  input  logic [35:0]           tx_csum_fifo_r_rd_data,
  input  logic                  tx_csum_fifo_r_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eof
);

  localparam int unsigned EntryW = 36;
  localparam int unsigned CntW   = 2;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_e;

  state_e                state_q;
  logic [EntryW-1:0]     entry_q;
  logic [CntW-1:0]       wcnt_q;
  logic [CntW-1:0]       wcnt_d;
  logic                  past_w3_q;
  logic                  rd_en_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic                  m_sof_q;
  logic                  m_eof_q;
  logic                  s_accept;

  logic [1:0]  eth_type;
  logic [15:0] ip_csum;
  logic [1:0]  ip_proto;
  logic [15:0] l4_csum;
  logic [15:0] udp_csum;

  assign eth_type = entry_q[1:0];
  assign ip_csum  = entry_q[17:2];
  assign ip_proto = entry_q[19:18];
  assign l4_csum  = entry_q[35:20];
  // UDP reserves zero for "no checksum"; a computed zero goes out as all-ones
  assign udp_csum = (l4_csum == 16'h0000) ? 16'hFFFF : l4_csum;

  assign s_ready  = (state_q == STREAM) && (!m_valid_q || m_ready);
  assign s_accept = s_valid && s_ready;

  assign wcnt_d = (wcnt_q == CntW'(3)) ? CntW'(3) : wcnt_q + CntW'(1);

  // Word index within the frame is wcnt_q; word 3 is distinguished from later words by past_w3_q
  always_comb begin
    m_data_d = s_data;
    if (ENABLE_IP && eth_type == 2'b01 && wcnt_q == CntW'(1)) begin
      m_data_d[64+:8] = ip_csum[15:8];
      m_data_d[72+:8] = ip_csum[7:0];
    end
    if (ENABLE_L4 && ip_proto == 2'b10 && wcnt_q == CntW'(2)) begin
      m_data_d[64+:8] = udp_csum[15:8];
      m_data_d[72+:8] = udp_csum[7:0];
    end
    if (ENABLE_L4 && ip_proto == 2'b01 && wcnt_q == CntW'(3) && !past_w3_q) begin
      m_data_d[16+:8] = l4_csum[15:8];
      m_data_d[24+:8] = l4_csum[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      entry_q   <= '0;
      wcnt_q    <= '0;
      past_w3_q <= 1'b0;
      rd_en_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tx_csum_fifo_r_empty) begin
            rd_en_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        // First FETCH cycle issues the read; the entry is latched on the second
        FETCH: begin
          if (rd_en_q) begin
            rd_en_q <= 1'b0;
          end else begin
            entry_q   <= tx_csum_fifo_r_rd_data;
            wcnt_q    <= '0;
            past_w3_q <= 1'b0;
            state_q   <= STREAM;
          end
        end
        STREAM: begin
          if (s_accept) begin
            wcnt_q <= wcnt_d;
            if (wcnt_q == CntW'(3)) past_w3_q <= 1'b1;
            if (s_eof) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (s_accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= m_data_d;
        m_sof_q   <= s_sof;
        m_eof_q   <= s_eof;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign tx_csum_fifo_r_rd_en = rd_en_q;
  assign m_valid              = m_valid_q;
  assign m_data               = m_data_q;
  assign m_sof                = m_sof_q;
  assign m_eof                = m_eof_q;

endmodule
